flush_ctrl: RTL and testbench
=============================

Name: flush_ctrl

Overview:
- Sequential successor to the combinational flush decode for the 5-stage pipeline.
- Resolves control-flow instructions in execute and raises a same-cycle `taken` for the PC mux.
- Drives a registered per-stage flush vector for FLUSH_CYCLES cycles; the window holds while the pipeline is stalled.
- Adds exception-priority flush, a cause code and a saturating taken-branch counter.

Parameters:
- STAGES, 2, number of younger pipeline stages killed (bit 0 = fetch, bit 1 = decode, ...).
- OPCODE_W, 5, opcode field width.
- FLUSH_CYCLES, 1, cycles `flush_vec` stays asserted per event (≥1).
- CNT_W, 16, width of the taken counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  execute-stage instruction is valid.
- opcode  in  OPCODE_W  execute-stage opcode.
- isNotEqual  in  1  ALU compare: operands differ.
- isLessThan  in  1  ALU compare: A < B.
- stall  in  1  pipeline frozen this cycle.
- exc_req  in  1  exception flush request.
- taken  out  1  combinational redirect select.
- flush_vec  out  STAGES  registered kill per stage.
- flush_cause  out  2  00 none, 01 branch, 10 jump, 11 exception.
- busy  out  1  flush window active.
- taken_count  out  CNT_W  saturating count of taken redirects.

Behaviour:
- Clock is `clock`; reset is synchronous, active-high, named `reset`.
- Reset values: `flush_vec` = 0, `flush_cause` = 00, `busy` = 0, `taken_count` = 0, state IDLE, down-counter 0.
- Decode, comparator-qualified:
  - j 00001, jal 00011, jr 00100: always taken, cause 10.
  - bne 00010: taken iff isNotEqual.
  - blt 00110: taken iff isNotEqual & ~isLessThan.
  - bex 10110: taken iff isNotEqual.
  - Conditional branches use cause 01.
  - All other opcodes: not taken.
- `taken` = ex_valid & decode_taken & (state == IDLE) & ~stall. Purely combinational, same cycle.
- FSM states: IDLE, FLUSH.
  - IDLE → FLUSH on the edge where `taken` = 1 or `exc_req` = 1.
  - On entry: counter ← FLUSH_CYCLES; `flush_cause` ← 11 if `exc_req`, else the branch/jump cause.
  - In FLUSH: `flush_vec` = all ones, `busy` = 1.
  - In FLUSH: counter decrements only when ~stall. At 0 → IDLE, `flush_vec` = 0, `flush_cause` = 00.
  - Latency: `flush_vec` asserts 1 cycle after `taken` and stays asserted for ≥ FLUSH_CYCLES cycles.
- Events while in FLUSH:
  - The execute instruction is wrong-path; decode is ignored and `taken` = 0.
  - `exc_req` in FLUSH reloads the counter to FLUSH_CYCLES and sets cause 11.
- Simultaneous `exc_req` and `taken` in IDLE: exception wins; cause 11. `taken` still drives the PC mux.
- `exc_req` while stall is asserted in IDLE still enters FLUSH.
- `taken_count`:
  - Increments on each cycle with `taken` = 1. Exceptions are not counted.
  - Saturates at 2^CNT_W − 1; no wrap.
- Reset mid-flush: the next edge returns to IDLE with all outputs zeroed; `taken_count` clears.
- Unknown opcodes never flush.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_BEX.
  - Cause encodings: CAUSE_NONE/BR/JMP/EXC.
  - FSM state encoding.
- One combinational sub-module, `branch_decode`: (opcode, isNotEqual, isLessThan) → (is_taken, cause).
- FSM, counters and output registers stay in `flush_ctrl`.

Test Plan:
- Reset held 2 cycles, then `opcode` = 00010, isNotEqual = 1, ex_valid = 1 → `taken` = 1 same cycle; next cycle `flush_vec` = 2'b11, cause = 01, busy = 1; following cycle all 0; `taken_count` = 1.
- blt (00110) with isNotEqual = 1, isLessThan = 1 → `taken` = 0, no flush. Then isLessThan = 0 → flush, cause 01.
- FLUSH_CYCLES = 3, jal taken, stall high for 2 cycles mid-window → `flush_vec` high for 5 cycles total, cause 10.
- Same cycle: `exc_req` = 1 and j (00001) → `taken` = 1, cause 11, `taken_count` +1. A second `exc_req` mid-window reloads the counter.
- CNT_W = 2, five taken jumps separated by idle cycles → `taken_count` sticks at 3.
- Reset asserted during FLUSH → next cycle `flush_vec` = 0, busy = 0, cause = 00, count = 0. Sweep of all 32 opcodes with both compare inputs → only the six control opcodes ever flush.

Source files
------------

// File: rtl/flush_ctrl_pkg.sv
// rtl/flush_ctrl_pkg.sv - shared opcode, cause and state encodings for flush_ctrl
// Purpose: constants shared by the flush controller and its branch decoder.
// Ports: none (package).
package flush_ctrl_pkg;

  typedef logic [1:0] cause_t;

  // Control-flow opcodes recognised in execute
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  // Flush cause encodings reported on flush_cause
  localparam cause_t CAUSE_NONE = 2'b00;
  localparam cause_t CAUSE_BR   = 2'b01;
  localparam cause_t CAUSE_JMP  = 2'b10;
  localparam cause_t CAUSE_EXC  = 2'b11;

  // Flush FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/branch_decode.sv
// rtl/branch_decode.sv - comparator-qualified control-flow decode
// Purpose: decide whether the execute-stage opcode redirects the PC and why.
// Ports:
//   opcode     in  execute-stage opcode
//   isNotEqual in  ALU compare, operands differ
//   isLessThan in  ALU compare, A < B
//   is_taken   out opcode redirects given the compare results
//   cause      out CAUSE_JMP / CAUSE_BR when taken, CAUSE_NONE otherwise
module branch_decode
  import flush_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                isNotEqual,
  input  logic                isLessThan,
  output logic                is_taken,
  output cause_t              cause
);

  always_comb begin
    is_taken = 1'b0;
    cause    = CAUSE_NONE;
    case (opcode)
      OPCODE_W'(OP_J), OPCODE_W'(OP_JAL), OPCODE_W'(OP_JR): begin
        is_taken = 1'b1;
        cause    = CAUSE_JMP;
      end
      OPCODE_W'(OP_BNE), OPCODE_W'(OP_BEX): begin
        is_taken = isNotEqual;
        cause    = isNotEqual ? CAUSE_BR : CAUSE_NONE;
      end
      // blt resolves on "differ and not less", i.e. A > B in the legacy ALU sense
      OPCODE_W'(OP_BLT): begin
        is_taken = isNotEqual & ~isLessThan;
        cause    = (isNotEqual & ~isLessThan) ? CAUSE_BR : CAUSE_NONE;
      end
      default: begin
        is_taken = 1'b0;
        cause    = CAUSE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/flush_ctrl.sv
// rtl/flush_ctrl.sv - pipeline flush controller with exception priority
// Purpose: raise a same-cycle redirect and a registered multi-cycle flush window.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   ex_valid, opcode    execute-stage instruction
//   isNotEqual, isLessThan  ALU compare results
//   stall               pipeline frozen this cycle
//   exc_req             exception flush request
//   taken               combinational PC-mux redirect select
//   flush_vec           registered kill per younger stage
//   flush_cause         00 none, 01 branch, 10 jump, 11 exception
//   busy                flush window active
//   taken_count         saturating count of taken redirects
module flush_ctrl
  import flush_ctrl_pkg::*;
#(
  parameter int STAGES       = 2,
  parameter int OPCODE_W     = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                isNotEqual,
  input  logic                isLessThan,
  input  logic                stall,
  input  logic                exc_req,
  output logic                taken,
  output logic [STAGES-1:0]   flush_vec,
  output logic [1:0]          flush_cause,
  output logic                busy,
  output logic [CNT_W-1:0]    taken_count
);

  localparam int                DCNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [0:0]        r_state;
  logic [DCNT_W-1:0] r_dcnt;
  logic [STAGES-1:0] r_flush_vec;
  cause_t            r_flush_cause;
  logic [CNT_W-1:0]  r_taken_count;

  logic   w_dec_taken;
  cause_t w_dec_cause;

  branch_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_branch_decode (
    .opcode     (opcode),
    .isNotEqual (isNotEqual),
    .isLessThan (isLessThan),
    .is_taken   (w_dec_taken),
    .cause      (w_dec_cause)
  );

  // While flushing, the execute instruction is wrong-path, so no redirect
  assign taken       = ex_valid & w_dec_taken & (r_state == ST_IDLE) & ~stall;
  assign busy        = (r_state == ST_FLUSH);
  assign flush_vec   = r_flush_vec;
  assign flush_cause = r_flush_cause;
  assign taken_count = r_taken_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_dcnt        <= '0;
      r_flush_vec   <= '0;
      r_flush_cause <= CAUSE_NONE;
      r_taken_count <= '0;
    end else begin
      if (taken && (r_taken_count != CNT_MAX)) begin
        r_taken_count <= r_taken_count + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // Exception entry does not depend on stall; it overrides the branch cause
          if (taken || exc_req) begin
            r_state       <= ST_FLUSH;
            r_dcnt        <= DCNT_LOAD;
            r_flush_vec   <= '1;
            r_flush_cause <= exc_req ? CAUSE_EXC : w_dec_cause;
          end
        end
        default: begin
          if (exc_req) begin
            r_dcnt        <= DCNT_LOAD;
            r_flush_cause <= CAUSE_EXC;
          end else if (!stall) begin
            // Leave on the edge that would take the count to zero
            if (r_dcnt == DCNT_W'(1)) begin
              r_state       <= ST_IDLE;
              r_dcnt        <= '0;
              r_flush_vec   <= '0;
              r_flush_cause <= CAUSE_NONE;
            end else begin
              r_dcnt <= r_dcnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flush_ctrl.sv
// tb/tb_flush_ctrl.sv - self-checking bench for flush_ctrl
module tb_flush_ctrl;

  logic       clock;
  logic       reset;
  logic       ex_valid;
  logic [4:0] opcode;
  logic       ne;
  logic       lt;
  logic       stall;
  logic       exc_req;

  logic        tk0, tk1, tk2;
  logic [1:0]  fv0, fv2;
  logic [2:0]  fv1;
  logic [1:0]  cs0, cs1, cs2;
  logic        by0, by1, by2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  // u0: defaults; u1: 3-cycle window, 3 stages; u2: 2-bit counter
  flush_ctrl u0 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .opcode(opcode),
    .isNotEqual(ne), .isLessThan(lt), .stall(stall), .exc_req(exc_req),
    .taken(tk0), .flush_vec(fv0), .flush_cause(cs0), .busy(by0), .taken_count(cnt0)
  );

  flush_ctrl #(.STAGES(3), .FLUSH_CYCLES(3)) u1 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .opcode(opcode),
    .isNotEqual(ne), .isLessThan(lt), .stall(stall), .exc_req(exc_req),
    .taken(tk1), .flush_vec(fv1), .flush_cause(cs1), .busy(by1), .taken_count(cnt1)
  );

  flush_ctrl #(.CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .opcode(opcode),
    .isNotEqual(ne), .isLessThan(lt), .stall(stall), .exc_req(exc_req),
    .taken(tk2), .flush_vec(fv2), .flush_cause(cs2), .busy(by2), .taken_count(cnt2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model: remaining non-stalled flush cycles per instance
  int fc   [3] = '{1, 3, 1};
  int stg  [3] = '{2, 3, 2};
  int cmax [3] = '{65535, 65535, 3};
  int m_rem   [3];
  int m_cause [3];
  int m_cnt   [3];
  bit m_valid = 1'b0;

  // Cause of a redirect from the decode table, 0 when not taken
  function automatic int dec_cause(input logic [4:0] op, input logic n, input logic l);
    case (op)
      5'b00001, 5'b00011, 5'b00100: return 2;
      5'b00010, 5'b10110:           return n ? 1 : 0;
      5'b00110:                     return (n && !l) ? 1 : 0;
      default:                      return 0;
    endcase
  endfunction

  always @(negedge clock) begin : cmp
    int g_tk, g_fv, g_cs, g_by, g_cnt, dc, tk_e;
    dc = dec_cause(opcode, ne, lt);
    for (int i = 0; i < 3; i++) begin
      tk_e = (ex_valid && dc != 0 && m_rem[i] == 0 && !stall) ? 1 : 0;
      if (m_valid) begin
        case (i)
          0: begin g_tk = int'(tk0); g_fv = int'(fv0); g_cs = int'(cs0); g_by = int'(by0); g_cnt = int'(cnt0); end
          1: begin g_tk = int'(tk1); g_fv = int'(fv1); g_cs = int'(cs1); g_by = int'(by1); g_cnt = int'(cnt1); end
          default: begin g_tk = int'(tk2); g_fv = int'(fv2); g_cs = int'(cs2); g_by = int'(by2); g_cnt = int'(cnt2); end
        endcase
        chk($sformatf("model.u%0d.taken", i), g_tk, tk_e);
        chk($sformatf("model.u%0d.flush_vec", i), g_fv, (m_rem[i] > 0) ? ((1 << stg[i]) - 1) : 0);
        chk($sformatf("model.u%0d.cause", i), g_cs, m_cause[i]);
        chk($sformatf("model.u%0d.busy", i), g_by, (m_rem[i] > 0) ? 1 : 0);
        chk($sformatf("model.u%0d.count", i), g_cnt, m_cnt[i]);
      end
      if (reset) begin
        m_rem[i] = 0; m_cause[i] = 0; m_cnt[i] = 0;
      end else if (m_rem[i] == 0) begin
        if (tk_e == 1 || exc_req) begin
          m_rem[i]   = fc[i];
          m_cause[i] = exc_req ? 3 : dc;
        end
        if (tk_e == 1 && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
      end else if (exc_req) begin
        m_rem[i] = fc[i]; m_cause[i] = 3;
      end else if (!stall) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) m_cause[i] = 0;
      end
    end
    if (reset) m_valid = 1'b1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] op, input logic n, input logic l,
                     input logic s, input logic e);
    ex_valid = v; opcode = op; ne = n; lt = l; stall = s; exc_req = e;
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 5'd0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int mask;
    int stl [7] = '{0, 1, 1, 0, 0, 0, 0};
    int exq [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    reset = 1'b1; ex_valid = 0; opcode = 0; ne = 0; lt = 0; stall = 0; exc_req = 0;
    tick(); tick();
    chk("rst.flush_vec", int'(fv0), 0);
    chk("rst.busy", int'(by0), 0);
    chk("rst.cause", int'(cs0), 0);
    chk("rst.count", int'(cnt0), 0);
    reset = 1'b0;

    // bne taken
    drv(1, 5'b00010, 1, 0, 0, 0);
    chk("bne.taken", int'(tk0), 1);
    tick();
    drv(0, 5'd0, 0, 0, 0, 0);
    chk("bne.flush_vec", int'(fv0), 3);
    chk("bne.cause", int'(cs0), 1);
    chk("bne.busy", int'(by0), 1);
    tick();
    chk("bne.clear_vec", int'(fv0), 0);
    chk("bne.clear_cause", int'(cs0), 0);
    chk("bne.count", int'(cnt0), 1);
    idle(3);

    // blt: not taken when less, taken when greater
    drv(1, 5'b00110, 1, 1, 0, 0);
    chk("blt.lt_taken", int'(tk0), 0);
    tick();
    chk("blt.lt_busy", int'(by0), 0);
    drv(1, 5'b00110, 1, 0, 0, 0);
    chk("blt.taken", int'(tk0), 1);
    tick();
    drv(0, 5'd0, 0, 0, 0, 0);
    chk("blt.cause", int'(cs0), 1);
    chk("blt.busy", int'(by0), 1);
    idle(3);

    // jal with a 3-cycle window stretched by a 2-cycle stall
    drv(1, 5'b00011, 0, 0, 0, 0);
    chk("jal.taken_u1", int'(tk1), 1);
    tick();
    n = 0;
    for (int k = 0; k < 7; k++) begin
      drv(0, 5'd0, 0, 0, stl[k][0], 0);
      if (fv1 != 3'b000) n++;
      if (k == 0) begin
        chk("jal.cause_u1", int'(cs1), 2);
        chk("jal.vec_u1", int'(fv1), 7);
      end
      tick();
    end
    chk("jal.window_u1", n, 5);

    // exception and jump together, then a reloading exception
    drv(1, 5'b00001, 0, 0, 0, 1);
    chk("excj.taken", int'(tk0), 1);
    tick();
    drv(0, 5'd0, 0, 0, 0, 0);
    chk("excj.cause", int'(cs0), 3);
    chk("excj.count", int'(cnt0), 4);
    chk("excj.cause_u1", int'(cs1), 3);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      drv(0, 5'd0, 0, 0, 0, exq[k][0]);
      if (by1) n++;
      tick();
    end
    chk("excj.reload_window_u1", n, 5);

    // exception while stalled in IDLE
    idle(2);
    drv(0, 5'd0, 0, 0, 1, 1);
    tick();
    drv(0, 5'd0, 0, 0, 0, 0);
    chk("excstall.busy", int'(by0), 1);
    chk("excstall.cause", int'(cs0), 3);
    chk("excstall.count", int'(cnt0), 4);
    idle(4);

    // reset in the middle of a window
    drv(1, 5'b00001, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    drv(0, 5'd0, 0, 0, 0, 0);
    chk("rstmid.pre_busy_u1", int'(by1), 1);
    tick();
    reset = 1'b0;
    chk("rstmid.vec", int'(fv0), 0);
    chk("rstmid.busy_u1", int'(by1), 0);
    chk("rstmid.cause_u1", int'(cs1), 0);
    chk("rstmid.count_u1", int'(cnt1), 0);

    // saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drv(1, 5'b00001, 0, 0, 0, 0);
      tick();
      idle(4);
    end
    chk("sat.count_u2", int'(cnt2), 3);
    chk("sat.count_u0", int'(cnt0), 5);

    // opcode sweep with every compare combination
    mask = 0;
    for (int op = 0; op < 32; op++) begin
      for (int c = 0; c < 4; c++) begin
        drv(1, op[4:0], c[0], c[1], 0, 0);
        if (tk0) mask = mask | (1 << op);
        tick();
        idle(4);
      end
    end
    chk("sweep.mask", mask, 32'h0040005E);
    chk("sweep.count_u0", int'(cnt0), 22);
    chk("sweep.count_u2", int'(cnt2), 3);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
